// File: rtl/mptw_req_arbiter_pkg.sv
// Shared MPT walker types: mmpt CSR layout, walk transaction, access types and
// the per-requester arbitration states.
package mptw_req_arbiter_pkg;

  localparam int MPTW_NUM_REQ = 2;
  localparam int MPTW_ID_W    = $clog2(MPTW_NUM_REQ);

  localparam logic [2:0] PERM_ALL = 3'b111;

  localparam logic [3:0] BARE_MODE    = 4'd0;
  localparam logic [3:0] SMMPT43_MODE = 4'd1;
  localparam logic [3:0] SMMPT52_MODE = 4'd2;
  localparam logic [3:0] SMMPT64_MODE = 4'd3;

  typedef logic [63:0]          spa_t;
  typedef logic [MPTW_ID_W-1:0] mptw_id_t;

  typedef enum logic [1:0] {
    ACC_R = 2'd0,
    ACC_W = 2'd1,
    ACC_X = 2'd2
  } access_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SLOT    = 2'd1,
    PENDING = 2'd2,
    BYPASS  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [3:0]  mode;
    logic [5:0]  sdid;
    logic [9:0]  reserved;
    logic [43:0] ppn;
  } mmpt_reg_t;

  typedef struct packed {
    spa_t      spa;
    mmpt_reg_t mmpt;
    access_t   access;
  } mptw_transaction_t;

  function automatic logic is_bare(input mmpt_reg_t m);
    return m.mode == BARE_MODE;
  endfunction

endpackage

// File: rtl/mptw_req_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester found at or after
// ptr, wrapping around; also reports the granted index.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_valid && req[i] && (i == (int'(ptr) + k) % N)) begin
          grant[i]    = 1'b1;
          grant_idx   = IDX_W'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mptw_req_arbiter.sv
// Shares the MPT walker between NUM_REQ requesters: round-robin issue into a
// registered slot, responses routed back by walk ID, BARE mode answered locally.
module mptw_req_arbiter
  import mptw_req_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = MPTW_NUM_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  mmpt_reg_t                 mmpt_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  spa_t [NUM_REQ-1:0]        req_spa_i,
  input  access_t [NUM_REQ-1:0]     req_access_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      walk_valid_o,
  input  logic                      walk_ready_i,
  output mptw_transaction_t         walk_transaction_o,
  output logic [ID_W-1:0]           walk_id_o,
  input  logic                      rsp_valid_i,
  input  logic [ID_W-1:0]           rsp_id_i,
  input  logic                      rsp_fault_i,
  input  logic [2:0]                rsp_perm_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [NUM_REQ-1:0]        rsp_fault_o,
  output logic [NUM_REQ-1:0][2:0]   rsp_perm_o
);

  arb_state_e                state_q [NUM_REQ];
  logic                      walk_valid_q;
  mptw_transaction_t         walk_trans_q;
  logic [ID_W-1:0]           walk_id_q;
  logic [ID_W-1:0]           rr_q;
  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic [NUM_REQ-1:0]        rsp_fault_q;
  logic [NUM_REQ-1:0][2:0]   rsp_perm_q;

  logic                      bare;
  logic                      slot_free;
  logic                      issue;
  logic                      grant_valid;
  logic [ID_W-1:0]           grant_idx;
  logic [NUM_REQ-1:0]        idle;
  logic [NUM_REQ-1:0]        rsp_hit;
  logic [NUM_REQ-1:0]        arb_req;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        accept;

  assign bare      = is_bare(mmpt_i);
  assign slot_free = ~walk_valid_q | walk_ready_i;

  // Out-of-range or non-PENDING response IDs never match, so they drop out here.
  always_comb begin
    idle    = '0;
    rsp_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idle[i]    = (state_q[i] == IDLE);
      rsp_hit[i] = rsp_valid_i && (state_q[i] == PENDING) && (rsp_id_i == ID_W'(i));
    end
  end

  assign arb_req = req_valid_i & idle & {NUM_REQ{~bare}};

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req         (arb_req),
    .ptr         (rr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = bare ? idle : (grant & {NUM_REQ{slot_free}});
  assign accept    = req_valid_i & req_ready;
  assign issue     = ~bare & grant_valid & slot_free;

  // Flush clears everything reset does except the fairness pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= IDLE;
      end
      walk_valid_q <= 1'b0;
      walk_trans_q <= '0;
      walk_id_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_fault_q  <= '0;
      rsp_perm_q   <= '0;
      if (rst_i) begin
        rr_q <= '0;
      end
    end else begin
      rsp_valid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        case (state_q[i])
          IDLE: begin
            if (accept[i]) begin
              if (bare) begin
                state_q[i]     <= BYPASS;
                rsp_valid_q[i] <= 1'b1;
                rsp_fault_q[i] <= 1'b0;
                rsp_perm_q[i]  <= PERM_ALL;
              end else begin
                state_q[i] <= SLOT;
              end
            end
          end
          SLOT: begin
            if (walk_valid_q && walk_ready_i) begin
              state_q[i] <= PENDING;
            end
          end
          PENDING: begin
            if (rsp_hit[i]) begin
              state_q[i]     <= IDLE;
              rsp_valid_q[i] <= 1'b1;
              rsp_fault_q[i] <= rsp_fault_i;
              rsp_perm_q[i]  <= rsp_perm_i;
            end
          end
          BYPASS: state_q[i] <= IDLE;
          default: state_q[i] <= IDLE;
        endcase
      end

      if (issue) begin
        walk_valid_q <= 1'b1;
        walk_trans_q <= '{spa: req_spa_i[grant_idx], mmpt: mmpt_i,
                          access: req_access_i[grant_idx]};
        walk_id_q    <= grant_idx;
        rr_q         <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else if (walk_ready_i) begin
        walk_valid_q <= 1'b0;
      end
    end
  end

  assign walk_valid_o       = walk_valid_q;
  assign walk_transaction_o = walk_trans_q;
  assign walk_id_o          = walk_id_q;
  assign req_ready_o        = req_ready;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_fault_o        = rsp_fault_q;
  assign rsp_perm_o         = rsp_perm_q;

endmodule

// File: tb/tb_mptw_req_arbiter.sv
// Bench for mptw_req_arbiter: a directed cycle table for the corner cases, then
// randomized traffic checked against a transaction-level reference model.
module tb_mptw_req_arbiter;
  import mptw_req_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam spa_t SPA0  = 64'h1000;
  localparam spa_t SPA1  = 64'h2000;
  localparam mmpt_reg_t MMPT_T    = '{mode: SMMPT43_MODE, sdid: 6'd5, reserved: '0, ppn: 44'h12345};
  localparam mmpt_reg_t MMPT_BARE = '{mode: BARE_MODE, sdid: '0, reserved: '0, ppn: '0};

  // where a requester's outstanding lookup currently lives
  localparam int M_FREE = 0;
  localparam int M_SLOT = 1;
  localparam int M_WALK = 2;
  localparam int M_BYP  = 3;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    flush_i;
  mmpt_reg_t               mmpt_i;
  logic [NUM_REQ-1:0]      req_valid_i;
  spa_t [NUM_REQ-1:0]      req_spa_i;
  access_t [NUM_REQ-1:0]   req_access_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic                    walk_valid_o;
  logic                    walk_ready_i;
  mptw_transaction_t       walk_transaction_o;
  logic [ID_W-1:0]         walk_id_o;
  logic                    rsp_valid_i;
  logic [ID_W-1:0]         rsp_id_i;
  logic                    rsp_fault_i;
  logic [2:0]              rsp_perm_i;
  logic [NUM_REQ-1:0]      rsp_valid_o;
  logic [NUM_REQ-1:0]      rsp_fault_o;
  logic [NUM_REQ-1:0][2:0] rsp_perm_o;

  always #5 clk_i = ~clk_i;

  mptw_req_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .mmpt_i             (mmpt_i),
    .req_valid_i        (req_valid_i),
    .req_spa_i          (req_spa_i),
    .req_access_i       (req_access_i),
    .req_ready_o        (req_ready_o),
    .walk_valid_o       (walk_valid_o),
    .walk_ready_i       (walk_ready_i),
    .walk_transaction_o (walk_transaction_o),
    .walk_id_o          (walk_id_o),
    .rsp_valid_i        (rsp_valid_i),
    .rsp_id_i           (rsp_id_i),
    .rsp_fault_i        (rsp_fault_i),
    .rsp_perm_i         (rsp_perm_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_fault_o        (rsp_fault_o),
    .rsp_perm_o         (rsp_perm_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Inputs for one cycle plus the outputs expected while those inputs are applied.
  typedef struct packed {
    logic       rst;
    logic       flush;
    logic       bare;
    logic [1:0] valid;
    logic       wready;
    logic       rvalid;
    logic       rid;
    logic [2:0] rperm;
    logic       rfault;
    logic       chk;
    logic [1:0] e_ready;
    logic       e_wvalid;
    logic       e_wid;
    logic [1:0] e_rvalid;
    logic [5:0] e_perm;
    logic [1:0] e_fault;
  } vec_t;

  vec_t vecs[$];

  int                      loc [NUM_REQ];
  mptw_transaction_t       slot_q[$];
  int                      slot_id_q[$];
  int                      rr_m;
  logic [NUM_REQ-1:0]      m_rsp_valid;
  logic [NUM_REQ-1:0]      m_rsp_fault;
  logic [NUM_REQ-1:0][2:0] m_rsp_perm;

  function automatic vec_t mk(input logic rst, flush, bare, input logic [1:0] valid,
                              input logic wready, rvalid, rid, input logic [2:0] rperm,
                              input logic rfault, chk, input logic [1:0] e_ready,
                              input logic e_wvalid, e_wid, input logic [1:0] e_rvalid,
                              input logic [5:0] e_perm, input logic [1:0] e_fault);
    vec_t v;
    v = '{rst, flush, bare, valid, wready, rvalid, rid, rperm, rfault,
          chk, e_ready, e_wvalid, e_wid, e_rvalid, e_perm, e_fault};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_i           = v.rst;
    flush_i         = v.flush;
    mmpt_i          = v.bare ? MMPT_BARE : MMPT_T;
    req_valid_i     = v.valid;
    req_spa_i[0]    = SPA0;
    req_spa_i[1]    = SPA1;
    req_access_i[0] = ACC_R;
    req_access_i[1] = ACC_W;
    walk_ready_i    = v.wready;
    rsp_valid_i     = v.rvalid;
    rsp_id_i        = v.rid;
    rsp_perm_i      = v.rperm;
    rsp_fault_i     = v.rfault;
  endtask

  function automatic logic [NUM_REQ-1:0] model_ready();
    logic [NUM_REQ-1:0] r;
    int pick;
    int j;
    r    = '0;
    pick = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (rr_m + k) % NUM_REQ;
      if (pick < 0 && req_valid_i[j] && loc[j] == M_FREE) pick = j;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mmpt_i.mode == BARE_MODE) r[i] = (loc[i] == M_FREE);
      else r[i] = (i == pick) && (slot_q.size() == 0 || walk_ready_i);
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REQ; i++) loc[i] = M_FREE;
    slot_q.delete();
    slot_id_q.delete();
    m_rsp_valid = '0;
  endtask

  task automatic model_edge(input logic [NUM_REQ-1:0] rdy);
    logic [NUM_REQ-1:0] acc;
    int id;
    acc = rdy & req_valid_i;
    if (rst_i) begin
      model_clear();
      rr_m = 0;
      return;
    end
    if (flush_i) begin
      model_clear();
      return;
    end
    m_rsp_valid = '0;
    id = int'(rsp_id_i);
    if (rsp_valid_i && id < NUM_REQ && loc[id] == M_WALK) begin
      loc[id]         = M_FREE;
      m_rsp_valid[id] = 1'b1;
      m_rsp_fault[id] = rsp_fault_i;
      m_rsp_perm[id]  = rsp_perm_i;
    end
    for (int i = 0; i < NUM_REQ; i++) if (loc[i] == M_BYP) loc[i] = M_FREE;
    if (slot_q.size() != 0 && walk_ready_i) begin
      loc[slot_id_q[0]] = M_WALK;
      void'(slot_q.pop_front());
      void'(slot_id_q.pop_front());
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        if (mmpt_i.mode == BARE_MODE) begin
          loc[i]         = M_BYP;
          m_rsp_valid[i] = 1'b1;
          m_rsp_fault[i] = 1'b0;
          m_rsp_perm[i]  = 3'b111;
        end else begin
          slot_q.push_back('{spa: req_spa_i[i], mmpt: mmpt_i, access: req_access_i[i]});
          slot_id_q.push_back(i);
          loc[i] = M_SLOT;
          rr_m   = (i + 1) % NUM_REQ;
        end
      end
    end
  endtask

  initial begin
    logic [NUM_REQ-1:0] exp_ready;
    logic [5:0]         pmask;
    mptw_transaction_t  exp_t;
    logic               seg_bare;

    // rst flush bare valid wr rv rid rperm rf | chk e_ready e_wv e_wid e_rv e_perm(o:p1p0) e_f
    vecs.push_back(mk(1,0,0,2'b00,0,0,0,3'b000,0, 0,2'b00,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,0,0,0,3'b000,0, 1,2'b00,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b01,1,0,0,3'b000,0, 1,2'b01,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,0,0,3'b000,0, 1,2'b00,1,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,1,0,3'b001,0, 1,2'b00,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,0,0,3'b000,0, 1,2'b00,0,0,2'b01,6'o01,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,0,0,3'b000,0, 1,2'b00,0,0,2'b00,6'o00,2'b00));
    // both requesting continuously: grants alternate 1,0,1,0
    vecs.push_back(mk(0,0,0,2'b11,1,0,0,3'b000,0, 1,2'b10,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b11,1,0,0,3'b000,0, 1,2'b01,1,1,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b11,1,1,1,3'b011,0, 1,2'b00,1,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b11,1,1,0,3'b101,0, 1,2'b10,0,0,2'b10,6'o30,2'b00));
    vecs.push_back(mk(0,0,0,2'b11,1,0,0,3'b000,0, 1,2'b01,1,1,2'b01,6'o05,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,1,1,3'b001,1, 1,2'b00,1,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,1,0,3'b010,0, 1,2'b00,0,0,2'b10,6'o10,2'b10));
    vecs.push_back(mk(0,0,0,2'b00,1,0,0,3'b000,0, 1,2'b00,0,0,2'b01,6'o02,2'b00));
    // walker stalled for five cycles with slot full
    vecs.push_back(mk(0,0,0,2'b01,0,0,0,3'b000,0, 1,2'b01,0,0,2'b00,6'o00,2'b00));
    for (int s = 0; s < 5; s++)
      vecs.push_back(mk(0,0,0,2'b10,0,0,0,3'b000,0, 1,2'b00,1,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b10,1,0,0,3'b000,0, 1,2'b10,1,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,0,0,3'b000,0, 1,2'b00,1,1,2'b00,6'o00,2'b00));
    // flush with req1 pending, stale response dropped, req1 re-accepted
    vecs.push_back(mk(0,1,0,2'b00,1,0,0,3'b000,0, 1,2'b00,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b10,1,1,1,3'b111,0, 1,2'b10,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,0,0,3'b000,0, 1,2'b00,1,1,2'b00,6'o00,2'b00));
    // reset with req0 pending and the slot full, then a late response
    vecs.push_back(mk(0,0,0,2'b01,0,0,0,3'b000,0, 1,2'b01,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,1,0,0,3'b000,0, 1,2'b00,1,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,0,1,1,3'b100,0, 1,2'b00,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b10,0,0,0,3'b000,0, 1,2'b10,0,0,2'b10,6'o40,2'b00));
    vecs.push_back(mk(1,0,0,2'b00,0,0,0,3'b000,0, 1,2'b00,1,1,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,0,1,0,3'b111,0, 1,2'b00,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,0,0,0,3'b000,0, 1,2'b00,0,0,2'b00,6'o00,2'b00));
    // BARE mode: both answered locally, nothing issued
    vecs.push_back(mk(0,0,1,2'b11,0,0,0,3'b000,0, 1,2'b11,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,1,2'b11,0,0,0,3'b000,0, 1,2'b00,0,0,2'b11,6'o77,2'b00));
    vecs.push_back(mk(0,0,1,2'b00,0,0,0,3'b000,0, 1,2'b11,0,0,2'b00,6'o00,2'b00));
    vecs.push_back(mk(0,0,0,2'b00,0,0,0,3'b000,0, 1,2'b00,0,0,2'b00,6'o00,2'b00));

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      #3;
      if (vecs[k].chk) begin
        checkOutput("tbl_ready", req_ready_o, vecs[k].e_ready);
        checkOutput("tbl_walk_valid", walk_valid_o, vecs[k].e_wvalid);
        if (vecs[k].e_wvalid) begin
          exp_t = '{spa: vecs[k].e_wid ? SPA1 : SPA0, mmpt: MMPT_T,
                    access: vecs[k].e_wid ? ACC_W : ACC_R};
          checkOutput("tbl_walk_id", walk_id_o, vecs[k].e_wid);
          checkOutput("tbl_walk_trans", walk_transaction_o, exp_t);
        end
        checkOutput("tbl_rsp_valid", rsp_valid_o, vecs[k].e_rvalid);
        pmask = {{3{vecs[k].e_rvalid[1]}}, {3{vecs[k].e_rvalid[0]}}};
        checkOutput("tbl_rsp_perm", rsp_perm_o & pmask, vecs[k].e_perm);
        checkOutput("tbl_rsp_fault", rsp_fault_o & vecs[k].e_rvalid, vecs[k].e_fault);
        if (k > 0 && vecs[k-1].rst) begin
          checkOutput("tbl_reset_trans", walk_transaction_o, '0);
          checkOutput("tbl_reset_id", walk_id_o, '0);
          checkOutput("tbl_reset_perm", rsp_perm_o, '0);
          checkOutput("tbl_reset_fault", rsp_fault_o, '0);
        end
      end
      @(posedge clk_i);
      #1;
    end

    rst_i = 1'b1;
    flush_i = 1'b0;
    req_valid_i = '0;
    rsp_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    model_clear();
    rr_m = 0;
    m_rsp_fault = '0;
    m_rsp_perm  = '0;

    for (int seg = 0; seg < 6; seg++) begin
      seg_bare = (seg % 3 == 2);
      for (int c = 0; c < 250; c++) begin
        rst_i          = ($urandom_range(0, 199) == 0);
        flush_i        = (c == 0) || ($urandom_range(0, 49) == 0);
        mmpt_i.mode    = seg_bare ? BARE_MODE : 4'($urandom_range(1, 3));
        mmpt_i.sdid    = 6'($urandom);
        mmpt_i.reserved = '0;
        mmpt_i.ppn     = 44'({$urandom(), $urandom()});
        for (int i = 0; i < NUM_REQ; i++) begin
          req_valid_i[i] = ($urandom_range(0, 9) < 6);
          req_spa_i[i]   = {$urandom(), $urandom()};
          case ($urandom_range(0, 2))
            0:       req_access_i[i] = ACC_R;
            1:       req_access_i[i] = ACC_W;
            default: req_access_i[i] = ACC_X;
          endcase
        end
        walk_ready_i = ($urandom_range(0, 9) < 7);
        rsp_valid_i  = ($urandom_range(0, 1) == 1);
        rsp_id_i     = ID_W'($urandom_range(0, NUM_REQ - 1));
        rsp_perm_i   = 3'($urandom);
        rsp_fault_i  = ($urandom_range(0, 3) == 0);
        #3;
        exp_ready = model_ready();
        checkOutput("rnd_ready", req_ready_o, exp_ready);
        checkOutput("rnd_walk_valid", walk_valid_o, slot_q.size() != 0);
        if (slot_q.size() != 0) begin
          checkOutput("rnd_walk_id", walk_id_o, slot_id_q[0]);
          checkOutput("rnd_walk_trans", walk_transaction_o, slot_q[0]);
        end
        checkOutput("rnd_rsp_valid", rsp_valid_o, m_rsp_valid);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (m_rsp_valid[i]) begin
            checkOutput("rnd_rsp_perm", rsp_perm_o[i], m_rsp_perm[i]);
            checkOutput("rnd_rsp_fault", rsp_fault_o[i], m_rsp_fault[i]);
          end
        end
        @(posedge clk_i);
        model_edge(exp_ready);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
